// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand/request and result handshake bundle for the iterative RV32M multiply/divide unit.
interface mul_div_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int FUNCT_LENGTH = 3
);
  logic                    Start;
  logic                    Flush;
  logic [FUNCT_LENGTH-1:0] Funct3;
  logic [DATA_WIDTH-1:0]   SrcA;
  logic [DATA_WIDTH-1:0]   SrcB;
  logic                    Busy;
  logic                    Done;
  logic [DATA_WIDTH-1:0]   MDResult;
  modport master (output Start, Flush, Funct3, SrcA, SrcB, input Busy, Done, MDResult);
  modport slave  (input Start, Flush, Funct3, SrcA, SrcB, output Busy, Done, MDResult);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 shift-add multiply / restoring divide over DATA_WIDTH cycles with Busy/Done handshake.
// Optional MDU_EARLY_OUT_EN: trivial requests (divide by zero, signed overflow, multiply by zero) skip CALC.
module mul_div_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int FUNCT_LENGTH = 3
) (
  input logic          clk,
  input logic          reset,
  mul_div_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] prod_q, prod_d, full;
  logic [W-1:0] b_q, b_d, res_q, res_d, ma, mb, diff, q_fix, r_fix;
  logic [FUNCT_LENGTH-1:0] op_q, op_d;
  logic neg_q, neg_d, negr_q, negr_d, done_q, done_d;
  logic sa, sb, is_div, ge;
  logic [W:0] madd;
  assign is_div = bus.Funct3[2];
  assign sa = bus.SrcA[W-1] & (is_div ? ~bus.Funct3[0] : (bus.Funct3[1] ^ bus.Funct3[0]));
  assign sb = bus.SrcB[W-1] & (is_div ? ~bus.Funct3[0] : (bus.Funct3[1:0] == 2'b01));
  assign ma = sa ? -bus.SrcA : bus.SrcA;
  assign mb = sb ? -bus.SrcB : bus.SrcB;
  // prod_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide
  assign madd = {1'b0, prod_q[2*W-1:W]} + {1'b0, prod_q[0] ? b_q : {W{1'b0}}};
  assign ge   = prod_q[2*W-1:W-1] >= {1'b0, b_q};
  assign diff = prod_q[2*W-2:W-1] - b_q;
  assign full  = neg_q ? -prod_q : prod_q;
  assign q_fix = neg_q ? -prod_q[W-1:0] : prod_q[W-1:0];
  assign r_fix = negr_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.Start && !bus.Flush) begin
        state_d = CALC;
        cnt_d   = '0;
        op_d    = bus.Funct3;
        b_d     = mb;
        prod_d  = {{W{1'b0}}, ma};
        neg_d   = (sa ^ sb) & (!is_div || bus.SrcB != '0);
        negr_d  = sa;
`ifdef MDU_EARLY_OUT_EN
        if (is_div && bus.SrcB == '0) begin
          state_d = FIX;
          prod_d  = {ma, {W{1'b1}}};
        end else if (is_div && !bus.Funct3[0] && bus.SrcA == {1'b1, {(W-1){1'b0}}} && &bus.SrcB) begin
          state_d = FIX;
          prod_d  = {{W{1'b0}}, bus.SrcA};
        end else if (!is_div && (bus.SrcA == '0 || bus.SrcB == '0)) begin
          state_d = FIX;
          prod_d  = '0;
        end
`else
`endif
      end
      CALC: if (bus.Flush) state_d = IDLE;
      else begin
        prod_d  = op_q[2] ? (ge ? {diff, prod_q[W-2:0], 1'b1} : {prod_q[2*W-2:0], 1'b0})
                          : {madd, prod_q[W-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(W-1)) ? FIX : CALC;
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.Flush) begin
          res_d  = op_q[2] ? (op_q[1] ? r_fix : q_fix)
                           : (op_q[1:0] == 2'b00 ? full[W-1:0] : full[2*W-1:W]);
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      b_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end
  assign bus.Busy     = state_q != IDLE;
  assign bus.Done     = done_q;
  assign bus.MDResult = res_q;
endmodule
